mips_mc_controller: RTL and testbench

- Multicycle control FSM that sequences the team's MIPS datapath: fetch, decode, execute, memory, writeback.
- Drives every datapath select/enable, the external memory read/write strobes and the halt/active status.
- Honours memory waitrequest and the ALU multiply/divide stall.
- Sits between the bus wrapper (memory handshake) and the datapath instance.

---
 rtl/mips_mc_controller_if.sv | 9 +
 rtl/mips_mc_controller.sv | 169 ++++++++++++++++
 tb/tb_mips_mc_controller.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_controller_if.sv
// rtl/mips_mc_controller_if.sv - memory handshake between controller and bus wrapper
interface mips_mc_controller_if;
  logic mem_read;
  logic mem_write;
  logic waitrequest;

  modport master (output mem_read, output mem_write, input waitrequest);
  modport slave  (input mem_read, input mem_write, output waitrequest);
endinterface

// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM
module mips_mc_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        reset,
  mips_mc_controller_if.master        mem,
  input  logic [31:0]                 instr,
  input  logic                        OUTLSB,
  input  logic                        stall,
  input  logic [31:0]                 pc_next,
  output logic                        PcEn,
  output logic                        IorD,
  output logic                        IrWrite,
  output logic                        IrSel,
  output logic                        RegDst,
  output logic                        MemToReg,
  output logic                        RegWrite,
  output logic                        ALUSrcA,
  output logic                        ExtSel,
  output logic                        ALUsel,
  output logic                        PCSrc,
  output logic                        is_jump,
  output logic [1:0]                  ALUSrcB,
  output logic [3:0]                  ALUControl,
  output logic [31:0]                 pc_init,
  output logic                        active
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_RTYP = 4'hF;

  logic [2:0] state;

  logic [5:0] op;
  logic [5:0] funct;
  logic [3:0] rt_hi;
  logic       is_r, is_jr, is_jalr, r_nowb, is_j, is_jal, dec_jump;
  logic       is_branch, is_ialu, is_load, is_store, is_logic_imm, halt_hit;
  logic [3:0] ialu_op;
  logic       rd, wr;
  logic       unused_instr;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign rt_hi = instr[20:17];
  assign unused_instr = ^{instr[25:21], instr[16:6]};

  // Instruction class decode; the IR is stable from EXEC onward.
  always_comb begin
    is_r         = (op == 6'h00);
    is_jr        = is_r && (funct == 6'h08);
    is_jalr      = is_r && (funct == 6'h09);
    // mult/div and mthi/mtlo only touch HI/LO, so they skip WB
    r_nowb       = is_r && (funct inside {6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B});
    is_j         = (op == 6'h02);
    is_jal       = (op == 6'h03);
    dec_jump     = is_j || is_jal || is_jr || is_jalr;
    // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1)
    is_branch    = (op inside {6'h04, 6'h05, 6'h06, 6'h07}) || ((op == 6'h01) && (rt_hi == 4'd0));
    is_ialu      = (op[5:3] == 3'b001);
    is_load      = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    is_store     = op inside {6'h28, 6'h29, 6'h2B};
    is_logic_imm = op inside {6'h0C, 6'h0D, 6'h0E};
    halt_hit     = (dec_jump || (is_branch && OUTLSB)) && (pc_next == HALT_ADDR);
    case (op[2:0])
      3'd0, 3'd1: ialu_op = 4'h0;
      3'd2:       ialu_op = 4'h5;
      3'd3:       ialu_op = 4'h6;
      3'd4:       ialu_op = 4'h2;
      3'd5:       ialu_op = 4'h3;
      3'd6:       ialu_op = 4'h4;
      default:    ialu_op = 4'h7;
    endcase
  end

  // State sequencing; waitrequest and stall only hold their own states.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (!mem.waitrequest) state <= S_DECODE;
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (!stall) begin
            if (halt_hit)                          state <= S_HALT;
            else if (is_load || is_store)          state <= S_MEM;
            else if (is_jal || is_jalr)            state <= S_WB;
            else if (dec_jump || is_branch || r_nowb) state <= S_FETCH;
            else if (is_r || is_ialu)              state <= S_WB;
            else                                   state <= S_FETCH;
          end
        end
        S_MEM:    if (!mem.waitrequest) state <= is_load ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Per-state control outputs; gated by reset so strobes drop as soon as it asserts.
  always_comb begin
    rd = 1'b0; wr = 1'b0;
    PcEn = 1'b0; IorD = 1'b0; IrWrite = 1'b0; IrSel = 1'b0;
    RegDst = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0;
    ExtSel = 1'b0; ALUsel = 1'b0; PCSrc = 1'b0; is_jump = 1'b0;
    ALUSrcB = 2'b00; ALUControl = ALU_ADD;
    if (reset) begin
      case (state)
        S_FETCH: rd = 1'b1;
        S_DECODE: begin
          IrWrite = 1'b1;
          ALUSrcB = 2'b01;
          PcEn    = 1'b1;
        end
        S_EXEC: begin
          IrSel  = 1'b1;
          ExtSel = is_logic_imm;
          if (is_r) begin
            ALUSrcA = 1'b1; ALUControl = ALU_RTYP;
          end else if (is_ialu) begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUControl = ialu_op;
          end else if (is_load || is_store) begin
            ALUSrcA = 1'b1; ALUSrcB = 2'b10;
          end else if (is_branch) begin
            ALUSrcA    = 1'b1;
            ALUControl = (op == 6'h04 || op == 6'h05) ? ALU_SUB : ALU_SLT;
            PCSrc      = 1'b1;
            PcEn       = OUTLSB && !stall;
          end
          if (dec_jump) begin
            is_jump = 1'b1;
            PcEn    = !stall;
          end
        end
        S_MEM: begin
          IrSel = 1'b1; IorD = 1'b1;
          rd = is_load; wr = is_store;
        end
        S_WB: begin
          IrSel    = 1'b1;
          RegWrite = 1'b1;
          RegDst   = is_r;
          MemToReg = !is_load;
          ALUsel   = !is_load;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_read  = rd;
  assign mem.mem_write = wr;
  assign pc_init       = RESET_VECTOR;
  assign active        = (state != S_HALT);

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - randomized self-checking bench for mips_mc_controller
module tb_mips_mc_controller;

  localparam int K_R = 0, K_RNW = 1, K_I = 2, K_LD = 3, K_ST = 4,
                 K_BR = 5, K_J = 6, K_JL = 7, K_UND = 8;
  localparam int NT = 25;

  typedef struct {
    logic [31:0] ins;
    int          kind;
    logic [3:0]  alu;
    logic [1:0]  srcb;
    logic        ext;
    logic        rdst;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        OUTLSB = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc_next = 32'h4;
  logic        PcEn, IorD, IrWrite, IrSel, RegDst, MemToReg, RegWrite;
  logic        ALUSrcA, ExtSel, ALUsel, PCSrc, is_jump, active;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ALUControl;
  logic [31:0] pc_init;

  int   n_checks = 0;
  int   n_fail = 0;
  ent_t tbl [NT];

  mips_mc_controller_if bus ();

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .mem(bus), .instr(instr), .OUTLSB(OUTLSB),
    .stall(stall), .pc_next(pc_next), .PcEn(PcEn), .IorD(IorD),
    .IrWrite(IrWrite), .IrSel(IrSel), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExtSel(ExtSel), .ALUsel(ALUsel),
    .PCSrc(PCSrc), .is_jump(is_jump), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .pc_init(pc_init), .active(active)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 with the FSM in FETCH; returns at the same point.
  task automatic run_instr(input int idx, input int fw, input int mw, input int st,
                           input logic lsb, input logic [31:0] pcn, input bit halt);
    ent_t e;
    bit   ldst, has_wb, jmp, chk_alu;
    int   len, xe, n_rd, n_wr, n_pc, n_rw, n_ir, n_io, n_both;
    string t;
    e       = tbl[idx];
    ldst    = (e.kind == K_LD) || (e.kind == K_ST);
    has_wb  = (e.kind == K_R) || (e.kind == K_I) || (e.kind == K_LD) || (e.kind == K_JL);
    jmp     = (e.kind == K_J) || (e.kind == K_JL);
    chk_alu = (e.kind <= K_ST);
    if (!(e.kind == K_R || e.kind == K_RNW)) st = 0;
    if (!ldst) mw = 0;
    case (e.kind)
      K_R, K_I, K_ST, K_JL: len = 4;
      K_LD:                 len = 5;
      default:              len = 3;
    endcase
    len = len + fw + mw + st;
    xe  = fw + 2 + st;
    n_rd = 0; n_wr = 0; n_pc = 0; n_rw = 0; n_ir = 0; n_io = 0; n_both = 0;
    instr = e.ins; OUTLSB = lsb; pc_next = pcn;
    t = $sformatf("i%0d", idx);
    for (int c = 0; c < len; c++) begin
      if (c <= fw) bus.waitrequest = (c < fw);
      else if (ldst && c >= fw + 3) bus.waitrequest = (c < fw + 3 + mw);
      else bus.waitrequest = 1'($urandom_range(0, 1));
      if (c >= fw + 2 && c <= xe) stall = (c < xe);
      else stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_rd += int'(bus.mem_read); n_wr += int'(bus.mem_write);
      n_pc += int'(PcEn); n_rw += int'(RegWrite); n_ir += int'(IrWrite);
      n_io += int'(IorD); n_both += int'(bus.mem_read && bus.mem_write);
      if (!active) n_both += 100;
      if (c == 0) check({t, "_fetch_rd"}, {IorD, bus.mem_read}, 2'b01);
      if (c == fw + 1) check({t, "_dec_sel"}, {IrSel, ALUSrcA, ALUSrcB, ALUControl}, {1'b0, 1'b0, 2'b01, 4'h0});
      if (c == fw + 2 && chk_alu)
        check({t, "_exec_alu"}, {IrSel, ExtSel, ALUSrcB, ALUControl}, {1'b1, e.ext, e.srcb, e.alu});
      if (c == xe && e.kind == K_BR) check({t, "_br_pcsrc"}, {PCSrc, is_jump}, 2'b10);
      if (c == xe && jmp) check({t, "_jump"}, is_jump, 1'b1);
      if (c == len - 1 && has_wb)
        check({t, "_wb"}, {RegDst, MemToReg, ALUsel}, {e.rdst, {2{e.kind != K_LD}}});
      @(posedge clk); #1;
    end
    check({t, "_n_rd"}, n_rd, fw + 1 + ((e.kind == K_LD) ? mw + 1 : 0));
    check({t, "_n_wr"}, n_wr, (e.kind == K_ST) ? mw + 1 : 0);
    check({t, "_n_pcen"}, n_pc, 1 + (jmp ? 1 : (e.kind == K_BR) ? int'(lsb) : 0));
    check({t, "_n_regwr"}, n_rw, has_wb ? 1 : 0);
    check({t, "_n_irw"}, n_ir, 1);
    check({t, "_n_iord"}, n_io, ldst ? mw + 1 : 0);
    check({t, "_excl_active"}, n_both, 0);
    if (halt) begin
      for (int c = 0; c < 4; c++) begin
        bus.waitrequest = 1'b0;
        @(negedge clk);
        check($sformatf("halt_c%0d", c), {active, bus.mem_read, bus.mem_write, PcEn}, 4'b0000);
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    tbl[0]  = '{32'h00221821, K_R,   4'hF, 2'b00, 1'b0, 1'b1};
    tbl[1]  = '{32'h00221823, K_R,   4'hF, 2'b00, 1'b0, 1'b1};
    tbl[2]  = '{32'h00220018, K_RNW, 4'hF, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{32'h0022001B, K_RNW, 4'hF, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{32'h24250010, K_I,   4'h0, 2'b10, 1'b0, 1'b0};
    tbl[5]  = '{32'h30A5000F, K_I,   4'h2, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{32'h34A5000F, K_I,   4'h3, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{32'h38A5000F, K_I,   4'h4, 2'b10, 1'b1, 1'b0};
    tbl[8]  = '{32'h28A5000F, K_I,   4'h5, 2'b10, 1'b0, 1'b0};
    tbl[9]  = '{32'h2CA5000F, K_I,   4'h6, 2'b10, 1'b0, 1'b0};
    tbl[10] = '{32'h3C051234, K_I,   4'h7, 2'b10, 1'b0, 1'b0};
    tbl[11] = '{32'h8C850008, K_LD,  4'h0, 2'b10, 1'b0, 1'b0};
    tbl[12] = '{32'h80850008, K_LD,  4'h0, 2'b10, 1'b0, 1'b0};
    tbl[13] = '{32'hAC850008, K_ST,  4'h0, 2'b10, 1'b0, 1'b0};
    tbl[14] = '{32'hA0850008, K_ST,  4'h0, 2'b10, 1'b0, 1'b0};
    tbl[15] = '{32'h10220004, K_BR,  4'h0, 2'b00, 1'b0, 1'b0};
    tbl[16] = '{32'h14220004, K_BR,  4'h0, 2'b00, 1'b0, 1'b0};
    tbl[17] = '{32'h04210004, K_BR,  4'h0, 2'b00, 1'b0, 1'b0};
    tbl[18] = '{32'h04200004, K_BR,  4'h0, 2'b00, 1'b0, 1'b0};
    tbl[19] = '{32'h08000010, K_J,   4'h0, 2'b00, 1'b0, 1'b0};
    tbl[20] = '{32'h0C000010, K_JL,  4'h0, 2'b00, 1'b0, 1'b0};
    tbl[21] = '{32'h03E00008, K_J,   4'h0, 2'b00, 1'b0, 1'b0};
    tbl[22] = '{32'h0020F809, K_JL,  4'h0, 2'b00, 1'b0, 1'b1};
    tbl[23] = '{32'hFC000000, K_UND, 4'h0, 2'b00, 1'b0, 1'b0};
    tbl[24] = '{32'h00000008, K_J,   4'h0, 2'b00, 1'b0, 1'b0};

    bus.waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {bus.mem_read, bus.mem_write, PcEn, IrWrite, RegWrite, IorD, ALUSrcB, ALUControl},
          10'b0);
    check("rst_active", active, 1'b1);
    check("pc_init", pc_init, 32'hBFC00000);
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(0, 0, 0, 0, 1'b0, 32'h100, 1'b0);
    run_instr(11, 0, 2, 0, 1'b0, 32'h104, 1'b0);
    run_instr(15, 0, 0, 0, 1'b1, 32'h108, 1'b0);
    run_instr(15, 0, 0, 0, 1'b0, 32'h10C, 1'b0);
    run_instr(2, 0, 0, 3, 1'b0, 32'h110, 1'b0);

    for (int k = 0; k < 60; k++)
      run_instr(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom | 32'h4, 1'b0);

    run_instr(24, 1, 0, 0, 1'b0, 32'h0, 1'b1);

    reset = 1'b0;
    @(negedge clk);
    check("halt_reset_active", active, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; instr = 32'hAC850008; stall = 1'b0; pc_next = 32'h200;
    for (int c = 0; c < 4; c++) begin
      bus.waitrequest = (c >= 3);
      @(posedge clk); #1;
    end
    check("sw_mid_wr", {bus.mem_write, IorD}, 2'b11);
    #2 reset = 1'b0;
    #1 check("sw_rst_drop", {bus.mem_write, bus.mem_read, IorD}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b1; bus.waitrequest = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", {bus.mem_read, IorD, active}, 3'b101);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_decode", {IrWrite, PcEn, bus.mem_read}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
